// File: rtl/regfile_pkg.sv
// Shared constants and index type for the register file with busy scoreboard.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH   = 64;
    localparam int unsigned DEFAULT_NUM_REGS     = 32;
    localparam int unsigned DEFAULT_NUM_READ     = 2;
    localparam int unsigned DEFAULT_NUM_WRITE    = 2;
    localparam int unsigned DEFAULT_NUM_REGS_LOG = $clog2(DEFAULT_NUM_REGS);

    typedef logic [DEFAULT_NUM_REGS_LOG-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_sb.sv
// Busy-bit scoreboard: one-deep reservation per register, write-back clear,
// flush squash and the combinational reservation handshake.
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS     = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_WRITE    = DEFAULT_NUM_WRITE,
    parameter int unsigned NUM_REGS_LOG = $clog2(NUM_REGS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            rsv_valid,
    input  logic [NUM_REGS_LOG-1:0]         rsv_addr,
    input  logic [NUM_WRITE-1:0]            wr_valid,
    input  logic [NUM_WRITE*NUM_REGS_LOG-1:0] wr_addr,
    output logic                            rsv_ready,
    output logic [NUM_REGS-1:0]             busy
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr_hit;

    // A same-cycle write-back to the requested index frees it in time for the new reservation.
    always_comb begin
        wr_hit = 1'b0;
        for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            if (wr_valid[w] && (wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG] == rsv_addr)) begin
                wr_hit = 1'b1;
            end
        end
        rsv_ready = rsv_valid && !flush && !reset &&
                    ((rsv_addr == '0) || !busy_q[rsv_addr] || wr_hit);
    end

    // Order matters: clears, then flush, then the reservation set wins.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned w = 0; w < NUM_WRITE; w++) begin
            if (wr_valid[w]) begin
                busy_d[wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end
        if (rsv_ready && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported register file with busy scoreboard; x0 is hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUM_REGS     = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_READ     = DEFAULT_NUM_READ,
    parameter int unsigned NUM_WRITE    = DEFAULT_NUM_WRITE,
    parameter int unsigned NUM_REGS_LOG = $clog2(NUM_REGS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_READ*NUM_REGS_LOG-1:0]  read_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    read_data,
    output logic [NUM_READ-1:0]               read_busy,
    input  logic [NUM_WRITE-1:0]              wr_valid,
    input  logic [NUM_WRITE*NUM_REGS_LOG-1:0] wr_addr,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0]   wr_data,
    input  logic                              rsv_valid,
    input  logic [NUM_REGS_LOG-1:0]           rsv_addr,
    output logic                              rsv_ready,
    input  logic                              flush
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;

    rf_scoreboard #(
        .NUM_REGS     (NUM_REGS),
        .NUM_WRITE    (NUM_WRITE),
        .NUM_REGS_LOG (NUM_REGS_LOG)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .rsv_ready (rsv_ready),
        .busy      (busy)
    );

    // Later write ports overwrite earlier ones, so the highest index wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                if (wr_valid[w] && (wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG] != '0)) begin
                    regs[wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG]] <= wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int unsigned p = 0; p < NUM_READ; p++) begin
            if (read_addr[p*NUM_REGS_LOG +: NUM_REGS_LOG] != '0) begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs[read_addr[p*NUM_REGS_LOG +: NUM_REGS_LOG]];
                read_busy[p] = busy[read_addr[p*NUM_REGS_LOG +: NUM_REGS_LOG]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned w = 0; w < NUM_WRITE; w++) begin
                    if (wr_valid[w] &&
                        (wr_addr[w*NUM_REGS_LOG +: NUM_REGS_LOG] == read_addr[p*NUM_REGS_LOG +: NUM_REGS_LOG])) begin
                        read_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[w*DATA_WIDTH +: DATA_WIDTH];
                        read_busy[p] = 1'b0;
                    end
                end
`endif
            end
        end
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter DATA_WIDTH, default 64, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, architectural register count (power of two, >=2).
REQ-003 Parameter NUM_READ, default 2, number of read ports.
REQ-004 Parameter NUM_WRITE, default 2, number of write-back ports.
REQ-005 Parameter NUM_REGS_LOG, default $clog2(NUM_REGS), index width.
REQ-006 clk  input  1  sole clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 read_addr  input  NUM_READ*NUM_REGS_LOG  packed read indices, port p at slice p.
REQ-009 read_data  output  NUM_READ*DATA_WIDTH  packed read data.
REQ-010 read_busy  output  NUM_READ  1 = addressed register has a pending write.
REQ-011 wr_valid  input  NUM_WRITE  write-back strobes.
REQ-012 wr_addr  input  NUM_WRITE*NUM_REGS_LOG  write-back indices.
REQ-013 wr_data  input  NUM_WRITE*DATA_WIDTH  write-back data.
REQ-014 rsv_valid  input  1  issue stage requests to mark rsv_addr busy.
REQ-015 rsv_addr  input  NUM_REGS_LOG  destination being reserved.
REQ-016 rsv_ready  output  1  reservation accepted this cycle.
REQ-017 flush  input  1  clear all busy bits (pipeline squash).

Function
REQ-018 Reads combinational, zero latency: read_data/read_busy reflect stored state for read_addr in the same cycle.
REQ-019 Register 0 reads 0 and busy 0 always; writes and reservations to index 0 are discarded without state change.
REQ-020 Write with wr_valid[w] updates registers[wr_addr[w]] on next edge and clears its busy bit.
REQ-021 Two write ports targeting one index same cycle: highest port index wins data; busy cleared.
REQ-022 rsv_ready = rsv_valid and (rsv_addr==0 or busy[rsv_addr]==0 or a write to rsv_addr is valid this cycle) and not flush.
REQ-023 Accepted reservation (rsv_valid and rsv_ready, rsv_addr!=0) sets busy[rsv_addr] at next edge; set takes priority over same-cycle write-back clear of that index.
REQ-024 Refused reservation leaves state unchanged; requester holds rsv_valid/rsv_addr until rsv_ready.
REQ-025 flush clears all busy bits at next edge; same-cycle writes still update data; same-cycle reservation refused.
REQ-026 Busy bit per register is one-deep: no second reservation while pending (WAW stall via rsv_ready).

Reset
REQ-027 reset sets every register to 0 and every busy bit to 0 at next edge; overrides writes, reservations and flush.
REQ-028 During reset cycle rsv_ready is 0; read outputs reflect pre-reset state until the edge, then 0/0.

Configuration
REQ-029 Macro REGFILE_BYPASS_EN defined: read port whose address matches a valid same-cycle write returns that wr_data (highest port wins) and read_busy 0.
REQ-030 REGFILE_BYPASS_EN undefined: reads return stored value and stored busy; write visible one cycle later.
REQ-031 Index 0 forwarding never applies in either build.

Structure
REQ-032 Shared package regfile_pkg holds default width/count constants and a reg_idx_t typedef sized by NUM_REGS_LOG default.
REQ-033 Sub-module rf_scoreboard holds busy vector, reservation/clear/flush logic and rsv_ready; data array stays in top.

Verification
REQ-034 reset, then read ports 0/1 at x5/x31 -> read_data 0, read_busy 0.
REQ-035 rsv x7 cycle 0 -> rsv_ready 1, read_busy(x7)=1 cycle 1; rsv x7 again -> rsv_ready 0; wr x7=0xDEAD cycle 3 -> cycle 4 data 0xDEAD, busy 0.
REQ-036 wr ports 0 and 1 both x9, data 0x11/0x22 -> x9 reads 0x22 next cycle.
REQ-037 wr x0=0xFFFF and rsv x0 -> x0 reads 0, busy 0, rsv_ready 1.
REQ-038 rsv x3,x4,x5 then flush -> all busy 0 next cycle, data unchanged; with REGFILE_BYPASS_EN wr x6=0x55 while reading x6 -> same-cycle read 0x55, without -> old value then 0x55.
REQ-039 reset asserted same cycle as wr x2=0x1 and rsv x2 -> x2 reads 0, busy 0 after edge.
